// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation minimum-SAD path:
// partition type codes, entry counts per type and default SAD widths.
package me_pkg;

    localparam int ME_W_S = 13;
    localparam int ME_W_M = 14;
    localparam int ME_W_L = 15;
    localparam int ME_W_X = 16;

    typedef enum logic [2:0] {
        PT_4X8   = 3'd0,
        PT_8X4   = 3'd1,
        PT_8X8   = 3'd2,
        PT_8X16  = 3'd3,
        PT_16X8  = 3'd4,
        PT_16X16 = 3'd5
    } pt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } rd_state_e;

    localparam int N_4X8       = 32;
    localparam int N_8X4       = 32;
    localparam int N_8X8       = 16;
    localparam int N_8X16      = 8;
    localparam int N_16X8      = 8;
    localparam int N_16X16     = 4;
    localparam int TOTAL_BEATS = N_4X8 + N_8X4 + N_8X8 + N_8X16 + N_16X8 + N_16X16;

    // Index of the final entry of a partition type; the counter wraps after it.
    function automatic logic [4:0] last_idx(input pt_e t);
        logic [4:0] r;
        case (t)
            PT_4X8:   r = 5'(N_4X8 - 1);
            PT_8X4:   r = 5'(N_8X4 - 1);
            PT_8X8:   r = 5'(N_8X8 - 1);
            PT_8X16:  r = 5'(N_8X16 - 1);
            PT_16X8:  r = 5'(N_16X8 - 1);
            default:  r = 5'(N_16X16 - 1);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sad_entry_mux.sv
// Selects one SAD entry from the packed snapshot by (type, idx) and
// zero-extends it to the common output width.
module sad_entry_mux
    import me_pkg::*;
#(
    parameter int W_S = ME_W_S,
    parameter int W_M = ME_W_M,
    parameter int W_L = ME_W_L,
    parameter int W_X = ME_W_X
) (
    input  logic [32*W_S-1:0] sad_4x8,
    input  logic [32*W_S-1:0] sad_8x4,
    input  logic [16*W_M-1:0] sad_8x8,
    input  logic [8*W_L-1:0]  sad_8x16,
    input  logic [8*W_L-1:0]  sad_16x8,
    input  logic [4*W_X-1:0]  sad_16x16,
    input  pt_e               sel_type,
    input  logic [4:0]        sel_idx,
    output logic [W_X-1:0]    sad
);

    // Index bits are trimmed to each vector's entry count so the part-select
    // can never reach past the top of a narrower vector.
    always_comb begin
        sad = '0;
        case (sel_type)
            PT_4X8:   sad = W_X'(sad_4x8[int'(sel_idx) * W_S +: W_S]);
            PT_8X4:   sad = W_X'(sad_8x4[int'(sel_idx) * W_S +: W_S]);
            PT_8X8:   sad = W_X'(sad_8x8[int'(sel_idx[3:0]) * W_M +: W_M]);
            PT_8X16:  sad = W_X'(sad_8x16[int'(sel_idx[2:0]) * W_L +: W_L]);
            PT_16X8:  sad = W_X'(sad_16x8[int'(sel_idx[2:0]) * W_L +: W_L]);
            PT_16X16: sad = sad_16x16[int'(sel_idx[1:0]) * W_X +: W_X];
            default:  sad = '0;
        endcase
    end

endmodule

// File: rtl/sad_result_reader.sv
// Read side of the minimum-SAD tracker: snapshots all 100 partition minima on
// start, streams them one per valid/ready beat and clears the tracker.
module sad_result_reader
    import me_pkg::*;
#(
    parameter int W_S = ME_W_S,
    parameter int W_M = ME_W_M,
    parameter int W_L = ME_W_L,
    parameter int W_X = ME_W_X
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [32*W_S-1:0] min_SAD4x8,
    input  logic [32*W_S-1:0] min_SAD8x4,
    input  logic [16*W_M-1:0] min_SAD8x8,
    input  logic [8*W_L-1:0]  min_SAD8x16,
    input  logic [8*W_L-1:0]  min_SAD16x8,
    input  logic [4*W_X-1:0]  min_SAD16x16,
    output logic              clr_min,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_type,
    output logic [4:0]        out_idx,
    output logic [W_X-1:0]    out_sad,
    output logic              busy,
    output logic              frame_done,
    output logic              start_drop
);

    rd_state_e         state_q, state_d;
    pt_e               type_q, type_d;
    logic [4:0]        idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic              clr_min_q, clr_min_d;
    logic              frame_done_q, frame_done_d;
    logic              start_drop_q, start_drop_d;
    logic [W_X-1:0]    out_sad_q, out_sad_d;

    logic [32*W_S-1:0] snap_4x8_q, snap_4x8_d;
    logic [32*W_S-1:0] snap_8x4_q, snap_8x4_d;
    logic [16*W_M-1:0] snap_8x8_q, snap_8x8_d;
    logic [8*W_L-1:0]  snap_8x16_q, snap_8x16_d;
    logic [8*W_L-1:0]  snap_16x8_q, snap_16x8_d;
    logic [4*W_X-1:0]  snap_16x16_q, snap_16x16_d;

    logic              handshake;

    assign handshake = out_valid_q && out_ready;

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        idx_d        = idx_q;
        out_valid_d  = out_valid_q;
        clr_min_d    = 1'b0;
        frame_done_d = 1'b0;
        start_drop_d = 1'b0;
        snap_4x8_d   = snap_4x8_q;
        snap_8x4_d   = snap_8x4_q;
        snap_8x8_d   = snap_8x8_q;
        snap_8x16_d  = snap_8x16_q;
        snap_16x8_d  = snap_16x8_q;
        snap_16x16_d = snap_16x16_q;

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (start) begin
                    snap_4x8_d   = min_SAD4x8;
                    snap_8x4_d   = min_SAD8x4;
                    snap_8x8_d   = min_SAD8x8;
                    snap_8x16_d  = min_SAD8x16;
                    snap_16x8_d  = min_SAD16x8;
                    snap_16x16_d = min_SAD16x16;
                    type_d       = PT_4X8;
                    idx_d        = '0;
                    out_valid_d  = 1'b1;
                    clr_min_d    = 1'b1;
                    state_d      = ST_SEND;
                end
            end

            ST_SEND: begin
                start_drop_d = start;
                if (handshake) begin
                    if (idx_q == last_idx(type_q)) begin
                        idx_d = '0;
                        if (type_q == PT_16X16) begin
                            out_valid_d  = 1'b0;
                            frame_done_d = 1'b1;
                            state_d      = ST_DONE;
                        end else begin
                            type_d = pt_e'(type_q + 3'd1);
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end

            ST_DONE: begin
                start_drop_d = start;
                out_valid_d  = 1'b0;
                state_d      = ST_IDLE;
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // out_sad is looked up from the next-cycle snapshot/position so it lands
    // in a register aligned with out_type/out_idx.
    sad_entry_mux #(
        .W_S (W_S),
        .W_M (W_M),
        .W_L (W_L),
        .W_X (W_X)
    ) u_entry_mux (
        .sad_4x8   (snap_4x8_d),
        .sad_8x4   (snap_8x4_d),
        .sad_8x8   (snap_8x8_d),
        .sad_8x16  (snap_8x16_d),
        .sad_16x8  (snap_16x8_d),
        .sad_16x16 (snap_16x16_d),
        .sel_type  (type_d),
        .sel_idx   (idx_d),
        .sad       (out_sad_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            type_q       <= PT_4X8;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            clr_min_q    <= 1'b0;
            frame_done_q <= 1'b0;
            start_drop_q <= 1'b0;
            out_sad_q    <= '0;
            snap_4x8_q   <= '0;
            snap_8x4_q   <= '0;
            snap_8x8_q   <= '0;
            snap_8x16_q  <= '0;
            snap_16x8_q  <= '0;
            snap_16x16_q <= '0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            clr_min_q    <= clr_min_d;
            frame_done_q <= frame_done_d;
            start_drop_q <= start_drop_d;
            out_sad_q    <= out_sad_d;
            snap_4x8_q   <= snap_4x8_d;
            snap_8x4_q   <= snap_8x4_d;
            snap_8x8_q   <= snap_8x8_d;
            snap_8x16_q  <= snap_8x16_d;
            snap_16x8_q  <= snap_16x8_d;
            snap_16x16_q <= snap_16x16_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_type   = type_q;
    assign out_idx    = idx_q;
    assign out_sad    = out_sad_q;
    assign clr_min    = clr_min_q;
    assign frame_done = frame_done_q;
    assign start_drop = start_drop_q;
    assign busy       = (state_q == ST_SEND) || (state_q == ST_DONE);

endmodule

// File: tb/tb_sad_result_reader.sv
// Self-checking bench for sad_result_reader: directed scenarios with random
// SAD contents compared against a per-beat reference list built from the inputs.
module tb_sad_result_reader;

    localparam int W_S = 13;
    localparam int W_M = 14;
    localparam int W_L = 15;
    localparam int W_X = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [32*W_S-1:0] min_SAD4x8;
    logic [32*W_S-1:0] min_SAD8x4;
    logic [16*W_M-1:0] min_SAD8x8;
    logic [8*W_L-1:0]  min_SAD8x16;
    logic [8*W_L-1:0]  min_SAD16x8;
    logic [4*W_X-1:0]  min_SAD16x16;
    logic              clr_min;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_type;
    logic [4:0]        out_idx;
    logic [W_X-1:0]    out_sad;
    logic              busy;
    logic              frame_done;
    logic              start_drop;

    int total = 0;
    int bad   = 0;

    int cnt [6] = '{32, 32, 16, 8, 8, 4};
    int wid [6] = '{13, 13, 14, 15, 15, 16};

    logic [15:0] vals [6][32];
    logic [15:0] cap  [6][32];

    always #5 clk = ~clk;

    sad_result_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .min_SAD4x8   (min_SAD4x8),
        .min_SAD8x4   (min_SAD8x4),
        .min_SAD8x8   (min_SAD8x8),
        .min_SAD8x16  (min_SAD8x16),
        .min_SAD16x8  (min_SAD16x8),
        .min_SAD16x16 (min_SAD16x16),
        .clr_min      (clr_min),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_type     (out_type),
        .out_idx      (out_idx),
        .out_sad      (out_sad),
        .busy         (busy),
        .frame_done   (frame_done),
        .start_drop   (start_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs(input bit zero);
        logic bv;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < cnt[t]; i++) begin
                for (int b = 0; b < wid[t]; b++) begin
                    bv = zero ? 1'b0 : vals[t][i][b];
                    case (t)
                        0: min_SAD4x8[i*W_S + b]   = bv;
                        1: min_SAD8x4[i*W_S + b]   = bv;
                        2: min_SAD8x8[i*W_M + b]   = bv;
                        3: min_SAD8x16[i*W_L + b]  = bv;
                        4: min_SAD16x8[i*W_L + b]  = bv;
                        default: min_SAD16x16[i*W_X + b] = bv;
                    endcase
                end
            end
        end
    endtask

    task automatic fill_random();
        for (int t = 0; t < 6; t++)
            for (int i = 0; i < 32; i++)
                vals[t][i] = (i < cnt[t]) ? 16'($urandom_range(0, (1 << wid[t]) - 1)) : 16'h0;
    endtask

    // Drives start at the current negedge and follows the whole stream.
    // mode 0: ready always high; mode 1: ready pattern 0,0,1.
    task automatic run_stream(input int mode, input int drop_beat, input int rst_beat);
        int cyc;
        int b;
        int drop_cycle;
        int et;
        int ei;
        bit drop_done;
        cap        = vals;
        drive_inputs(1'b0);
        start      = 1'b1;
        out_ready  = (mode == 0);
        cyc        = 0;
        b          = 0;
        drop_cycle = -1;
        drop_done  = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            chk("clr_min", 32'(clr_min), 32'(cyc == 1));
            chk("start_drop", 32'(start_drop), 32'(cyc == drop_cycle));
            if (b == 100) begin
                chk("frame_done", 32'(frame_done), 32'd1);
                chk("frame_cycle", 32'(cyc), (mode == 0) ? 32'd101 : 32'd301);
                chk("valid_after_last", 32'(out_valid), 32'd0);
                chk("busy_done", 32'(busy), 32'd1);
                break;
            end
            et = 0;
            ei = b;
            while (ei >= cnt[et]) begin
                ei -= cnt[et];
                et++;
            end
            chk("frame_done_early", 32'(frame_done), 32'd0);
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("out_type", 32'(out_type), 32'(et));
            chk("out_idx", 32'(out_idx), 32'(ei));
            chk("out_sad", 32'(out_sad), 32'(cap[et][ei]));
            if (b == rst_beat) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_frame_done", 32'(frame_done), 32'd0);
                chk("rst_clr_min", 32'(clr_min), 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    chk("post_rst_frame_done", 32'(frame_done), 32'd0);
                    chk("post_rst_valid", 32'(out_valid), 32'd0);
                end
                out_ready = 1'b0;
                return;
            end
            if (b == drop_beat && !drop_done) begin
                drop_done  = 1'b1;
                start      = 1'b1;
                drive_inputs(1'b1);
                drop_cycle = cyc + 1;
            end
            out_ready = (mode == 0) || (cyc % 3 == 0);
            if (out_ready) b++;
            if (cyc > 400) begin
                chk("stream_timeout", 32'(cyc), 32'd0);
                break;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int t = 0; t < 6; t++)
            for (int i = 0; i < 32; i++)
                vals[t][i] = 16'h0;
        drive_inputs(1'b0);
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_clr_min", 32'(clr_min), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_start_drop", 32'(start_drop), 32'd0);
        chk("reset_type", 32'(out_type), 32'd0);
        chk("reset_idx", 32'(out_idx), 32'd0);
        chk("reset_sad", 32'(out_sad), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic ordered stream, entry i carries i+1
        for (int t = 0; t < 6; t++)
            for (int i = 0; i < 32; i++)
                vals[t][i] = (i < cnt[t]) ? 16'(i + 1) : 16'h0;
        run_stream(0, -1, -1);
        $display("stream basic done: total=%0d bad=%0d", total, bad);

        // back-to-back start on the cycle after frame_done
        @(negedge clk);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_frame_done_gone", 32'(frame_done), 32'd0);
        fill_random();
        run_stream(0, -1, -1);
        $display("stream back_to_back done: total=%0d bad=%0d", total, bad);

        repeat (2) @(negedge clk);
        fill_random();
        run_stream(1, -1, -1);
        $display("stream backpressure done: total=%0d bad=%0d", total, bad);

        repeat (2) @(negedge clk);
        fill_random();
        vals[0][31] = 16'h1FFF;
        vals[2][15] = 16'h3FFF;
        vals[4][7]  = 16'h7FFF;
        vals[5][0]  = 16'hFFFF;
        run_stream(0, -1, -1);
        $display("stream width_extremes done: total=%0d bad=%0d", total, bad);

        repeat (2) @(negedge clk);
        fill_random();
        run_stream(0, 10, -1);
        $display("stream start_drop done: total=%0d bad=%0d", total, bad);

        repeat (2) @(negedge clk);
        fill_random();
        run_stream(1, 10, -1);
        $display("stream start_drop_backpressure done: total=%0d bad=%0d", total, bad);

        repeat (2) @(negedge clk);
        fill_random();
        run_stream(0, -1, 50);
        $display("stream reset_mid done: total=%0d bad=%0d", total, bad);

        fill_random();
        run_stream(0, -1, -1);
        $display("stream after_reset done: total=%0d bad=%0d", total, bad);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
